// File: rtl/ram_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module  : ram_stream_reader_if
// Brief   : valid/ready/last word stream between the RAM reader and a consumer.
// Revision: 1.0
// ============================================================================
interface ram_stream_reader_if #(
    parameter int DW = 16
);
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module  : ram_stream_reader
// Brief   : streams len words from a 1-cycle-latency RAM read port onto a
//           valid/ready/last stream through a 2-entry skid buffer.
//           Optional macro RAM_STREAM_READER_STRIDE_EN adds a stride input.
// Revision: 1.0
// ============================================================================
module ram_stream_reader #(
    parameter int AW = 7,
    parameter int DW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [AW-1:0]       base_addr,
    input  logic [AW:0]         len,
`ifdef RAM_STREAM_READER_STRIDE_EN
    input  logic [AW-1:0]       stride,
`endif
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       ram_addr,
    input  logic [DW-1:0]       ram_data,
    ram_stream_reader_if.master m
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] addr_q;
    logic [AW:0]   issue_rem_q, issue_rem_d;
    logic [AW:0]   accept_rem_q, accept_rem_d;
    logic          done_q, done_d;
    logic          inflight_q, inflight_last_q;

    logic [DW-1:0] buf_data_q [2];
    logic [1:0]    buf_last_q;
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    count_q;

    logic [AW-1:0] step;
    logic          issue, accept, fill, pop;
    logic          head_valid, head_last;
    logic [DW-1:0] head_data;

`ifdef RAM_STREAM_READER_STRIDE_EN
    logic [AW-1:0] step_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            step_q <= stride;
        end
    end

    assign step = step_q;
`else
    assign step = {{(AW-1){1'b0}}, 1'b1};
`endif

    // Issue only when the returning word is guaranteed a buffer slot.
    assign issue = (state_q == S_RUN) && (issue_rem_q != '0) &&
                   ((count_q + {1'b0, inflight_q}) < 2'd2);

    // Empty buffer falls through to the word arriving from the RAM this cycle.
    assign head_valid = (count_q != 2'd0) || inflight_q;
    assign head_data  = (count_q != 2'd0) ? buf_data_q[rd_ptr_q] : ram_data;
    assign head_last  = (count_q != 2'd0) ? buf_last_q[rd_ptr_q] : inflight_last_q;

    assign accept = head_valid && m.m_ready;
    assign fill   = inflight_q && !((count_q == 2'd0) && accept);
    assign pop    = accept && (count_q != 2'd0);

    assign m.m_valid = head_valid;
    assign m.m_data  = head_valid ? head_data : '0;
    assign m.m_last  = head_valid && head_last;

    assign ram_addr = issue ? ptr_q : addr_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        issue_rem_d  = issue_rem_q;
        accept_rem_d = accept_rem_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = S_RUN;
                        ptr_d        = base_addr;
                        issue_rem_d  = len;
                        accept_rem_d = len;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    ptr_d       = ptr_q + step;
                    issue_rem_d = issue_rem_q - LEN_ONE;
                    if (issue_rem_q == LEN_ONE) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept && (state_q != S_IDLE)) begin
            accept_rem_d = accept_rem_q - LEN_ONE;
            if (accept_rem_q == LEN_ONE) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            addr_q          <= '0;
            issue_rem_q     <= '0;
            accept_rem_q    <= '0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            issue_rem_q     <= issue_rem_d;
            accept_rem_q    <= accept_rem_d;
            done_q          <= done_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && (issue_rem_q == LEN_ONE);
            if (issue) begin
                addr_q <= ptr_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
            end
            buf_last_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (fill) begin
                buf_data_q[wr_ptr_q] <= ram_data;
                buf_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, fill} - {1'b0, pop};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_stream_reader
// Brief   : directed self-checking bench for ram_stream_reader.
// Revision: 1.0
// ============================================================================
module tb_ram_stream_reader;
    localparam int AW = 7;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
`ifdef RAM_STREAM_READER_STRIDE_EN
    logic [AW-1:0] stride;
`endif
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] mem [2**AW];

    int total = 0;
    int bad   = 0;

    ram_stream_reader_if #(.DW(DW)) s ();

    ram_stream_reader #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
`ifdef RAM_STREAM_READER_STRIDE_EN
        .stride    (stride),
`endif
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .m         (s)
    );

    always #5 clk = ~clk;

    // RAM read port: address registered, data one cycle later.
    always @(posedge clk) ram_data <= mem[ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_at(input logic [AW-1:0] a);
        return 32'(16'hA000 | 16'(a));
    endfunction

    // mode 0: m_ready held high; mode 1: m_ready pattern 1,0,0,1.
    task automatic xfer(input logic [AW-1:0] b, input int n_len, input int mode, input int stray);
        int            n        = 0;
        int            last_acc = -1;
        bit            fin      = 1'b0;
        logic          pv       = 1'b0;
        logic          pr       = 1'b0;
        logic          pl       = 1'b0;
        logic [DW-1:0] pd       = '0;
        logic [AW-1:0] ea;
        nxt();
        start     = 1'b1;
        base_addr = b;
        len       = n_len[AW:0];
        s.m_ready = (mode == 0);
        #2;
        chk("x_busy_at_start", 32'(busy), 32'(0));
        for (int c = 1; c <= 400 && !fin; c++) begin
            nxt();
            start = (c == stray);
            if (c == stray) begin
                base_addr = '0;
                len       = 8'd3;
            end
            s.m_ready = (mode == 0) ? 1'b1 : ((c % 4 == 1) || (c % 4 == 0));
            #2;
            if (pv && !pr) begin
                chk("stall_valid", 32'(s.m_valid), 32'(1));
                chk("stall_data", 32'(s.m_data), 32'(pd));
                chk("stall_last", 32'(s.m_last), 32'(pl));
            end
            if (mode == 0 && c <= n_len) begin
                ea = b + AW'(c - 1);
                chk("issue_addr", 32'(ram_addr), 32'(ea));
            end
            if (done) begin
                chk("done_timing", 32'(c), 32'(last_acc + 1));
                chk("word_count", 32'(n), 32'(n_len));
                chk("done_busy", 32'(busy), 32'(0));
                chk("done_valid", 32'(s.m_valid), 32'(0));
                fin = 1'b1;
            end else begin
                chk("busy_during", 32'(busy), 32'(1));
                if (s.m_valid && s.m_ready) begin
                    ea = b + AW'(n);
                    chk("stream_data", 32'(s.m_data), word_at(ea));
                    chk("stream_last", 32'(s.m_last), 32'(n == n_len - 1));
                    n++;
                    last_acc = c;
                end
            end
            pv = s.m_valid;
            pr = s.m_ready;
            pd = s.m_data;
            pl = s.m_last;
        end
        if (!fin) chk("xfer_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = 16'(32'hA000 + i);
`ifdef RAM_STREAM_READER_STRIDE_EN
        stride = 7'd1;
`endif
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        s.m_ready = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_addr", 32'(ram_addr), 32'(0));
        chk("rst_valid", 32'(s.m_valid), 32'(0));
        chk("rst_data", 32'(s.m_data), 32'(0));
        chk("rst_last", 32'(s.m_last), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // base 5, len 4: exact cycle-by-cycle latency
        nxt();
        start = 1'b1; base_addr = 7'd5; len = 8'd4; s.m_ready = 1'b1;
        #2 chk("t1_c0_busy", 32'(busy), 32'(0));
        nxt();
        start = 1'b0;
        #2;
        chk("t1_c1_busy", 32'(busy), 32'(1));
        chk("t1_c1_addr", 32'(ram_addr), 32'(5));
        chk("t1_c1_valid", 32'(s.m_valid), 32'(0));
        for (int k = 0; k < 4; k++) begin
            nxt();
            #2;
            chk("t1_valid", 32'(s.m_valid), 32'(1));
            chk("t1_data", 32'(s.m_data), 32'(16'hA005 + 16'(k)));
            chk("t1_last", 32'(s.m_last), 32'(k == 3));
            chk("t1_done_early", 32'(done), 32'(0));
        end
        nxt();
        #2;
        chk("t1_done", 32'(done), 32'(1));
        chk("t1_busy_fall", 32'(busy), 32'(0));
        chk("t1_valid_off", 32'(s.m_valid), 32'(0));
        nxt();
        #2 chk("t1_done_pulse", 32'(done), 32'(0));

        // len 0: no busy, no data, a single done pulse
        nxt();
        start = 1'b1; base_addr = 7'd9; len = 8'd0;
        nxt();
        start = 1'b0;
        #2;
        chk("t0_done", 32'(done), 32'(1));
        chk("t0_busy", 32'(busy), 32'(0));
        chk("t0_valid", 32'(s.m_valid), 32'(0));
        nxt();
        #2;
        chk("t0_done_pulse", 32'(done), 32'(0));
        chk("t0_busy2", 32'(busy), 32'(0));

        // address wrap, backpressure with a stray start, full RAM sweep
        xfer(7'd126, 4, 0, -1);
        xfer(7'd10, 8, 1, 2);
        xfer(7'd0, 128, 0, -1);

        // back-to-back start in the done cycle
        start = 1'b1; base_addr = 7'd3; len = 8'd2; s.m_ready = 1'b1;
        nxt();
        start = 1'b0;
        #2;
        chk("b2b_busy", 32'(busy), 32'(1));
        chk("b2b_addr", 32'(ram_addr), 32'(3));
        chk("b2b_done_once", 32'(done), 32'(0));
        nxt();
        #2 chk("b2b_data0", 32'(s.m_data), 32'(16'hA003));
        nxt();
        #2;
        chk("b2b_data1", 32'(s.m_data), 32'(16'hA004));
        chk("b2b_last", 32'(s.m_last), 32'(1));
        nxt();
        #2 chk("b2b_done", 32'(done), 32'(1));

        // reset mid-transfer after 3 of 10 words
        nxt();
        start = 1'b1; base_addr = 7'd20; len = 8'd10;
        nxt();
        start = 1'b0;
        repeat (4) nxt();
        #2;
        chk("ab_mid_valid", 32'(s.m_valid), 32'(1));
        chk("ab_mid_data", 32'(s.m_data), 32'(16'hA017));
        rst = 1'b1;
        #1;
        chk("ab_busy", 32'(busy), 32'(0));
        chk("ab_valid", 32'(s.m_valid), 32'(0));
        chk("ab_data", 32'(s.m_data), 32'(0));
        chk("ab_last", 32'(s.m_last), 32'(0));
        chk("ab_addr", 32'(ram_addr), 32'(0));
        chk("ab_done", 32'(done), 32'(0));
        nxt();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nxt();
            #2;
            chk("ab_no_done", 32'(done), 32'(0));
            chk("ab_no_valid", 32'(s.m_valid), 32'(0));
        end
        xfer(7'd0, 2, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side controller for the single-clock dual-port RAM with registered read address (one-cycle read latency).
- Streams len consecutive words starting at base_addr out of the RAM's read port and presents them on a valid/ready stream with a last marker.
- Internal 2-entry buffer absorbs downstream backpressure without losing in-flight reads.
- Sits between the RAM read port (ram_addr drives the read address, ram_data receives the read data) and a downstream consumer.

Parameters:
AW, 7, RAM address width; depth = 2^AW.
DW, 16, RAM data width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous reset, active-high.
start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
base_addr  input  AW  first RAM address; sampled with start.
len  input  AW+1  word count, 0..2^AW; sampled with start.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse when the last word is accepted downstream.
ram_addr  output  AW  RAM read address.
ram_data  input  DW  RAM read data; valid one cycle after ram_addr is driven.
m_valid  output  1  stream data valid.
m_data  output  DW  stream data.
m_last  output  1  high with the final word of a transfer.
m_ready  input  1  downstream accept.

Behaviour:
- Reset values (async, immediate): busy=0, done=0, ram_addr=0, m_valid=0, m_data=0, m_last=0, buffer empty, state IDLE, no read in flight.
- States:
  - IDLE: start=1 with len>0 -> RUN; captures base_addr into the address pointer and len into the remaining-issue and remaining-accept counters. start with len=0 stays in IDLE, produces no busy, and pulses done the next cycle.
  - RUN: one address is issued per cycle while issue_rem>0 and (buffer occupancy + in-flight) < 2. In-flight is 0 or 1. When issue_rem reaches 0 -> DRAIN.
  - DRAIN: waits until accept_rem reaches 0, then -> IDLE with a one-cycle done pulse.
- Issue: ram_addr holds the issued address. The word returned on ram_data in the following cycle is written into the buffer tagged with last = (accept index == len-1).
- ram_addr holds its value when no read is issued.
- Address arithmetic: pointer increments modulo 2^AW. base_addr=2^AW-1 with len=2 reads addresses 2^AW-1 then 0.
- Stream: the head of the buffer drives m_valid, m_data and m_last. A transfer occurs when m_valid and m_ready are both high. m_data and m_last are stable while m_valid=1 and m_ready=0.
- Buffer: same-cycle fill and drain is allowed at any occupancy.
- Throughput: 1 word/cycle with m_ready held high.
- Latency: start at cycle 0, first address at cycle 1, first m_valid at cycle 2.
- start while busy is ignored. len=2^AW reads the whole RAM exactly once.
- done is asserted in the cycle after the m_last transfer; busy falls in that same cycle.
- A new start is accepted in the done cycle.
- rst mid-transfer aborts immediately: the buffer and the in-flight read are discarded, no done pulse is produced, and all outputs return to reset values.

Optional Feature:
- Macro RAM_STREAM_READER_STRIDE_EN.
- Defined: adds input stride (AW bits), sampled with start. The pointer advances by stride modulo 2^AW; stride=0 rereads base_addr len times.
- Undefined: no stride port; the increment is fixed at 1.

Test Plan:
- Preload RAM[i]=16'hA000+i. Start base=5, len=4, m_ready=1 -> m_data A005,A006,A007,A008 on consecutive cycles 2..5; m_last with A008; done at cycle 6.
- Base=126, len=4 (AW=7) -> addresses 126,127,0,1 and data A07E,A07F,A000,A001.
- Len=8 with m_ready toggling 1,0,0,1 repeatedly -> all 8 words in order, none duplicated or lost; m_data held stable during stalls; ram_addr never issued with buffer+in-flight>=2.
- Len=0 -> no m_valid, busy stays 0, done pulses once. Start asserted during busy -> ignored, transfer unaffected.
- Len=128, m_ready=1 -> 128 words, done exactly once. Back-to-back start in the done cycle -> second transfer begins without a gap cycle.
- Assert rst after 3 of 10 words -> outputs return to 0 asynchronously, no done. A following start with base=0, len=2 -> A000,A001.
